// File: rtl/stopwatch_counter_pkg.sv
// Shared types and widths for the stopwatch counter.
package stopwatch_pkg;
  localparam int BCD_W   = 4;
  localparam int PRESC_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_pair_t;
endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses in, display digits and status out.
interface stopwatch_counter_if;
    logic                              start;
    logic                              stop;
    logic                              clear;
    logic                              lap;
    logic [stopwatch_pkg::BCD_W-1:0]   seconds_ones;
    logic [stopwatch_pkg::BCD_W-1:0]   seconds_tens;
    logic [stopwatch_pkg::PRESC_W-1:0] prescale_count;
    logic                              running;
    logic                              done;
    logic [stopwatch_pkg::BCD_W-1:0]   lap_ones;
    logic [stopwatch_pkg::BCD_W-1:0]   lap_tens;
    logic                              lap_valid;

    modport master (
        output start, stop, clear, lap,
        input  seconds_ones, seconds_tens, prescale_count, running, done,
               lap_ones, lap_tens, lap_valid
    );
    modport slave (
        input  start, stop, clear, lap,
        output seconds_ones, seconds_tens, prescale_count, running, done,
               lap_ones, lap_tens, lap_valid
    );
endinterface

// File: rtl/stopwatch_counter_digit.sv
// One BCD decade: counts 0..9 on inc, wraps with carry.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);
    assign carry = inc & (q == BCD_W'(9));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= '0;
        else if (clr) q <= '0;
        else if (inc) q <= carry ? '0 : q + BCD_W'(1);
    end
endmodule

// File: rtl/stopwatch_counter.sv
// Up-counting BCD stopwatch: prescaler, run/pause/done FSM, saturation and lap capture.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 51,
    parameter int MAX_TENS = 9,
    parameter int MAX_ONES = 9
) (
    input  logic                clk,
    input  logic                reset,
    stopwatch_counter_if.slave  sw
);
    localparam int STAGES = 1;

    sw_state_e          state, nstate;
    logic [PRESC_W-1:0] presc;
    logic [BCD_W-1:0]   ones, tens, nxt_o, nxt_t;
    logic               carry_o, carry_t;
    logic               tick, hit, cap;
    bcd_pair_t          lap_q;
    logic [STAGES:0]    vld_pipe;

    // stop and clear both pre-empt the advance on the edge they arrive
    assign tick = (state == RUNNING) && !sw.clear && !sw.stop &&
                  (presc == PRESC_W'(PRESCALE - 1));
    assign cap  = sw.lap && !sw.clear && (state != IDLE);

    bcd_digit_counter u_ones (
        .clk(clk), .reset(reset), .clr(sw.clear), .inc(tick),
        .q(ones), .carry(carry_o)
    );
    bcd_digit_counter u_tens (
        .clk(clk), .reset(reset), .clr(sw.clear), .inc(carry_o),
        .q(tens), .carry(carry_t)
    );

    // compare the post-tick value so DONE lands on the same edge as the limit
    always_comb begin
        nxt_o = carry_o ? '0 : ones + BCD_W'(1);
        nxt_t = carry_o ? (carry_t ? '0 : tens + BCD_W'(1)) : tens;
        hit   = tick && (nxt_t == BCD_W'(MAX_TENS)) && (nxt_o == BCD_W'(MAX_ONES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (sw.clear) nstate = IDLE;
        else begin
            case (state)
                IDLE:    if (sw.start) nstate = RUNNING;
                RUNNING: if (sw.stop)  nstate = PAUSED;
                         else if (hit) nstate = DONE;
                PAUSED:  if (sw.start) nstate = RUNNING;
                default: nstate = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         presc <= '0;
        else if (sw.clear) presc <= '0;
        else if (state == RUNNING && !sw.stop)
            presc <= tick ? '0 : presc + PRESC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q    <= '0;
            vld_pipe <= '0;
        end else if (sw.clear) begin
            lap_q    <= '0;
            vld_pipe <= '0;
        end else begin
            if (cap) lap_q <= '{tens: tens, ones: ones};
            vld_pipe <= {vld_pipe[STAGES-1:0], cap};
        end
    end

    assign sw.seconds_ones   = ones;
    assign sw.seconds_tens   = tens;
    assign sw.prescale_count = presc;
    assign sw.running        = (state == RUNNING);
    assign sw.done           = (state == DONE);
    assign sw.lap_ones       = lap_q.ones;
    assign sw.lap_tens       = lap_q.tens;
    assign sw.lap_valid      = vld_pipe[STAGES];
endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Up-counting stopwatch, the count-up counterpart of the team's countdown timer block. A free-running prescaler divides `clk` into one-second ticks, which advance a two-digit BCD seconds count from 00 to a programmable limit. Start/stop/clear/lap controls come from debounced button logic. Digit and status outputs feed the seven-segment display driver.

## Interface
- `PRESCALE`, 51: clock cycles per second tick; the prescaler counts 0..PRESCALE-1; range 2..128.
- `MAX_TENS`, 9: tens digit of the saturation value; range 0..9.
- `MAX_ONES`, 9: ones digit of the saturation value; range 0..9; MAX_TENS:MAX_ONES ≠ 00.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state to reset values immediately.
- `start`  in  1  one-cycle pulse; begin or resume counting.
- `stop`  in  1  one-cycle pulse; pause counting.
- `clear`  in  1  one-cycle pulse; return to zero from any state.
- `lap`  in  1  one-cycle pulse; capture the current digits.
- `seconds_ones`  out  4  BCD ones digit, 0..9.
- `seconds_tens`  out  4  BCD tens digit, 0..9.
- `prescale_count`  out  7  current prescaler value.
- `running`  out  1  high in RUNNING.
- `done`  out  1  high in DONE (limit reached).
- `lap_ones`, `lap_tens`  out  4 each  captured digits.
- `lap_valid`  out  1  one-cycle pulse, the cycle after a capture.

## Operation
- States: IDLE, RUNNING, PAUSED, DONE; encoding 2 bits.
- Input priority per edge: `clear` > `stop` > `start`; `lap` is independent.
- IDLE:
  - Digits, prescaler, and lap registers are 0.
  - `start` → RUNNING; prescaler stays 0 on that edge.
- RUNNING:
  - The prescaler increments each edge.
  - At PRESCALE-1, the prescaler wraps to 0 and generates one tick.
  - On a tick, ones increments. At 9, ones wraps to 0 and tens increments.
  - If the tick produces MAX_TENS:MAX_ONES → DONE, and the prescaler goes to 0.
  - `stop` → PAUSED. `stop` suppresses the prescaler advance and the tick on that edge.
  - `start` while RUNNING is ignored.
- PAUSED:
  - Digits and prescaler are held.
  - `start` → RUNNING; the prescaler resumes from its held value on the following edge.
- DONE:
  - Digits hold at the limit, the prescaler holds at 0, and `done`=1.
  - `start` and `stop` are ignored.
- `clear` in any state → IDLE next edge; digits, prescaler, and lap registers go to 0.
- `lap` in RUNNING, PAUSED, or DONE captures the pre-edge digits. `lap` in IDLE is ignored.
- `lap` together with a tick captures the value before the increment.
- `lap` together with `clear`: clear wins, and `lap_valid` stays 0.
- Widths: digits are 4-bit BCD and never exceed 9; the prescaler is 7 bits wide and zero-extended to the output.

## Timing
- Reset values:
  - State is IDLE.
  - All digits, `prescale_count`, and lap registers are 0.
  - `running`, `done`, and `lap_valid` are 0.
- Outputs are registered, with no combinational input-to-output path.
- `running` asserts on the edge that samples `start`.
- From that edge N, `prescale_count` reads 1..PRESCALE-1 after edges N+1..N+PRESCALE-1.
- The first digit increment occurs on edge N+PRESCALE, which gives exactly PRESCALE cycles per second.
- `lap_valid` pulses for exactly one cycle, on the edge after the capture edge; the lap digits remain stable until the next capture or clear.
- Reset asserted mid-count returns all outputs to their reset values asynchronously. Counting resumes only after deassertion plus a `start`.

## Structure
- Package `stopwatch_pkg`:
  - State localparams IDLE=0, RUNNING=1, PAUSED=2, DONE=3.
  - Constants: `BCD_W`=4, `PRESC_W`=7.
- Sub-module `bcd_digit_counter`:
  - Ports: clk, reset, clr, inc, q[3:0], carry.
  - `carry` = inc & (q==9).
  - Instantiated twice (ones, tens); the ones `carry` drives the tens `inc`.
- The top level holds the FSM, prescaler, saturation compare, and lap registers.

## Test plan
- Reset, then `start` at cycle 0 with PRESCALE=51 → `prescale_count` reads 50 at cycle 50; digits become 01 at cycle 51 and 10 at cycle 510.
- Run to 05, pulse `stop` at prescale 20 → digits stay 05 and prescale 20 for 100 cycles. `start` → prescale reads 21 one edge later.
- Run with MAX_TENS=1, MAX_ONES=2 → `done`=1 and `running`=0 at digits 12. Further `start` has no effect; `clear` → 00, IDLE.
- `lap` on the same edge as the 07→08 tick → `lap_tens`:`lap_ones`=0:7 and `lap_valid` high for one cycle; the live digits read 08.
- `clear` and `start` in the same cycle while PAUSED → IDLE with all outputs 0. `clear` and `lap` together → `lap_valid` stays 0.
- Assert `reset` mid-count at digits 37 → all outputs 0 immediately, without waiting for `clk`; after release, no counting until `start`.
